// File: rtl/prach_pkg.sv
// Shared constants, phase encoding and the saturating/wrapping width reducer
// used by the radix-3 DIT butterfly stages.
package prach_pkg;

  localparam int DW = 18;
  // Working width for the reducer; wide enough for any practical DW+1 input.
  localparam int CW = 32;

  typedef enum logic [1:0] {
    PH_S = 2'd0,
    PH_A = 2'd1,
    PH_B = 2'd2
  } phase_e;

  typedef struct packed {
    logic [CW-1:0] val;
    logic          clip;
  } sat_res_t;

  // Reduce a sign-extended (w+1)-bit value to w bits. clip flags any value
  // outside the w-bit range, whether it was clamped (sat=1) or wrapped (sat=0).
  function automatic sat_res_t sat_add(input logic signed [CW-1:0] x,
                                       input int                   w,
                                       input logic                 sat);
    sat_res_t            r;
    logic signed [CW-1:0] hi;
    logic signed [CW-1:0] lo;
    logic signed [CW-1:0] wrapped;
    hi      = (CW'(1) << (w - 1)) - CW'(1);
    lo      = ~hi;
    wrapped = (x <<< (CW - w)) >>> (CW - w);
    r.clip  = (x > hi) || (x < lo);
    if (!r.clip) begin
      r.val = x;
    end else if (sat) begin
      r.val = (x > hi) ? hi : lo;
    end else begin
      r.val = wrapped;
    end
    return r;
  endfunction

endpackage

// File: rtl/prach_ditfft3_bf3_delay.sv
// Fixed-length register delay line with synchronous clear, used to align
// side-band flags with the datapath latency.
module prach_ditfft3_bf3_delay #(
  parameter int WIDTH = 2,
  parameter int DELAY = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] pipe_reg [DELAY];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DELAY; i++) begin
        pipe_reg[i] <= '0;
      end
    end else begin
      pipe_reg[0] <= d;
      for (int i = 1; i < DELAY; i++) begin
        pipe_reg[i] <= pipe_reg[i-1];
      end
    end
  end

  assign q = pipe_reg[DELAY-1];

endmodule

// File: rtl/prach_ditfft3_bf3.sv
// Radix-3 DIT final combine: consumes (S, A, B) triples and emits
// (S, A+B, A-B) in natural order with a fixed 3-cycle latency.
module prach_ditfft3_bf3
  import prach_pkg::*;
#(
  parameter int DW  = prach_pkg::DW,
  parameter bit SAT = 1'b1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din_dr,
  input  logic [DW-1:0] din_di,
  input  logic          din_dv,
  input  logic          sync_in,
  output logic [DW-1:0] dout_dr,
  output logic [DW-1:0] dout_di,
  output logic          dout_dv,
  output logic          sync_out,
  output logic          ovf,
  output logic          err
);

  phase_e phase_reg;
  phase_e phase_next;

  logic sync_start;
  logic ld_s;
  logic ld_a;
  logic ld_b;
  logic proto_err;
  logic kill_a;

  logic s_tag_d1_reg;
  logic s_tag_d2_reg;
  logic y1_pend_reg;
  logic y2_pend_reg;
  logic kill_d1_reg;
  logic kill_d2_reg;
  logic err_reg;
  logic ovf_reg;

  logic [DW-1:0] din_lane  [2];
  logic [DW-1:0] dout_lane [2];
  logic [1:0]    sum_clip;
  logic [1:0]    diff_clip;

  logic [1:0] dly_d;
  logic [1:0] dly_q;

  assign sync_start = din_dv & sync_in;

  // Phase FSM: state register
  always_ff @(posedge clk) begin
    if (rst) begin
      phase_reg <= PH_S;
    end else begin
      phase_reg <= phase_next;
    end
  end

  // Phase FSM: next state. A sync sample always restarts at phase 0, so the
  // following sample is phase 1.
  always_comb begin
    phase_next = phase_reg;
    unique case (phase_reg)
      PH_S: begin
        if (din_dv) phase_next = PH_A;
      end
      PH_A, PH_B: begin
        if (sync_start) begin
          phase_next = PH_A;
        end else if (!din_dv) begin
          phase_next = PH_S;
        end else begin
          phase_next = (phase_reg == PH_A) ? PH_B : PH_S;
        end
      end
      default: phase_next = PH_S;
    endcase
  end

  // Phase FSM: per-cycle controls
  always_comb begin
    ld_s      = din_dv & ((phase_reg == PH_S) | sync_start);
    ld_a      = din_dv & ~sync_start & (phase_reg == PH_A);
    ld_b      = din_dv & ~sync_start & (phase_reg == PH_B);
    proto_err = (phase_reg != PH_S) & (~din_dv | sync_start);
    kill_a    = proto_err & (phase_reg == PH_B);
  end

  // Slot tags: S launches y0 two cycles after capture; a completed B
  // schedules y1 then y2 on the next two output cycles.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_tag_d1_reg <= 1'b0;
      s_tag_d2_reg <= 1'b0;
      y1_pend_reg  <= 1'b0;
      y2_pend_reg  <= 1'b0;
      kill_d1_reg  <= 1'b0;
      kill_d2_reg  <= 1'b0;
      err_reg      <= 1'b0;
      ovf_reg      <= 1'b0;
    end else begin
      s_tag_d1_reg <= ld_s;
      s_tag_d2_reg <= s_tag_d1_reg;
      y1_pend_reg  <= ld_b;
      y2_pend_reg  <= y1_pend_reg;
      kill_d1_reg  <= kill_a;
      kill_d2_reg  <= kill_d1_reg;
      err_reg      <= proto_err;
      ovf_reg      <= (y1_pend_reg & |sum_clip) | (y2_pend_reg & |diff_clip);
    end
  end

  assign din_lane[0] = din_dr;
  assign din_lane[1] = din_di;

  // Lane 0 carries the real part, lane 1 the imaginary part.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_lane
      logic [DW-1:0]      hold_s_reg;
      logic [DW-1:0]      hold_s2_reg;
      logic [DW-1:0]      hold_a_reg;
      logic [DW-1:0]      sum_reg;
      logic [DW-1:0]      diff_reg;
      logic [DW-1:0]      dout_reg;
      logic               sum_clip_reg;
      logic               diff_clip_reg;
      logic signed [DW:0] sum_w;
      logic signed [DW:0] diff_w;
      sat_res_t           sum_res;
      sat_res_t           diff_res;
      logic               res_unused;

      assign sum_w  = $signed({hold_a_reg[DW-1], hold_a_reg})
                    + $signed({din_lane[gi][DW-1], din_lane[gi]});
      assign diff_w = $signed({hold_a_reg[DW-1], hold_a_reg})
                    - $signed({din_lane[gi][DW-1], din_lane[gi]});

      assign sum_res    = sat_add({{(CW-DW-1){sum_w[DW]}}, sum_w}, DW, SAT);
      assign diff_res   = sat_add({{(CW-DW-1){diff_w[DW]}}, diff_w}, DW, SAT);
      assign res_unused = ^{sum_res.val[CW-1:DW], diff_res.val[CW-1:DW]};

      always_ff @(posedge clk) begin
        if (rst) begin
          hold_s_reg    <= '0;
          hold_s2_reg   <= '0;
          hold_a_reg    <= '0;
          sum_reg       <= '0;
          diff_reg      <= '0;
          sum_clip_reg  <= 1'b0;
          diff_clip_reg <= 1'b0;
          dout_reg      <= '0;
        end else begin
          if (ld_s) hold_s_reg <= din_lane[gi];
          // Second S stage keeps y0 intact when a sync restart reloads hold_s.
          hold_s2_reg <= hold_s_reg;
          if (ld_a) hold_a_reg <= din_lane[gi];
          if (ld_b) begin
            sum_reg       <= sum_res.val[DW-1:0];
            diff_reg      <= diff_res.val[DW-1:0];
            sum_clip_reg  <= sum_res.clip;
            diff_clip_reg <= diff_res.clip;
          end
          if (y2_pend_reg) begin
            dout_reg <= diff_reg;
          end else if (y1_pend_reg) begin
            dout_reg <= sum_reg;
          end else if (s_tag_d2_reg) begin
            dout_reg <= hold_s2_reg;
          end else begin
            dout_reg <= '0;
          end
        end
      end

      assign dout_lane[gi] = dout_reg;
      assign sum_clip[gi]  = sum_clip_reg;
      assign diff_clip[gi] = diff_clip_reg;
    end
  endgenerate

  assign dly_d = {sync_start, din_dv};

  prach_ditfft3_bf3_delay #(
    .WIDTH(2),
    .DELAY(3)
  ) u_align (
    .clk(clk),
    .rst(rst),
    .d  (dly_d),
    .q  (dly_q)
  );

  // An aborted triple keeps its launched y0 but drops the A slot; the
  // missing-B slot already carries no valid.
  assign dout_dv  = dly_q[0] & ~kill_d2_reg;
  assign sync_out = dly_q[1];
  assign dout_dr  = dout_lane[0];
  assign dout_di  = dout_lane[1];
  assign ovf      = ovf_reg;
  assign err      = err_reg;

endmodule

// File: tb/tb_prach_ditfft3_bf3.sv
// Directed and table-driven checks of the radix-3 final combine stage, with a
// saturating and a wrapping instance driven from the same stimulus.
module tb_prach_ditfft3_bf3;

  localparam int DW   = 18;
  localparam int NLOG = 1024;
  localparam int VMAX = 131071;
  localparam int VMIN = -131072;

  logic          clk = 1'b0;
  logic          rst;
  logic [DW-1:0] din_dr;
  logic [DW-1:0] din_di;
  logic          din_dv;
  logic          sync_in;

  logic [DW-1:0] dout_dr, dout_di;
  logic          dout_dv, sync_out, ovf, err;
  logic [DW-1:0] w_dr, w_di;
  logic          w_dv, w_sync, w_ovf, w_err;

  prach_ditfft3_bf3 #(.DW(DW), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(dout_dr), .dout_di(dout_di), .dout_dv(dout_dv),
    .sync_out(sync_out), .ovf(ovf), .err(err)
  );

  prach_ditfft3_bf3 #(.DW(DW), .SAT(1'b0)) dut_wrap (
    .clk(clk), .rst(rst), .din_dr(din_dr), .din_di(din_di), .din_dv(din_dv),
    .sync_in(sync_in), .dout_dr(w_dr), .dout_di(w_di), .dout_dv(w_dv),
    .sync_out(w_sync), .ovf(w_ovf), .err(w_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int lg_r [NLOG];
  int lg_i [NLOG];
  int lg_wr[NLOG];
  int lg_wi[NLOG];
  bit lg_dv[NLOG];
  bit lg_sy[NLOG];
  bit lg_ovf[NLOG];
  bit lg_err[NLOG];
  bit lg_wovf[NLOG];

  always @(negedge clk) begin
    if (cyc < NLOG) begin
      lg_r[cyc]    = $signed(dout_dr);
      lg_i[cyc]    = $signed(dout_di);
      lg_wr[cyc]   = $signed(w_dr);
      lg_wi[cyc]   = $signed(w_di);
      lg_dv[cyc]   = dout_dv;
      lg_sy[cyc]   = sync_out;
      lg_ovf[cyc]  = ovf;
      lg_err[cyc]  = err;
      lg_wovf[cyc] = w_ovf;
    end
  end

  typedef struct {
    int sr, si, ar, ai, br, bi;
    int y1r, y1i, y2r, y2i;
    bit o1, o2;
    int w1r, w1i, w2r, w2i;
    bit wo1, wo2;
  } vec_t;

  typedef struct {
    int t0;
    int sr, si, y1r, y1i, y2r, y2i;
    bit o1, o2, sy;
    int w1r, w1i, w2r, w2i;
    bit wo1, wo2;
  } exp_t;

  exp_t expq[$];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, req);
    end
  endtask

  task automatic drive(input bit v, input bit s, input int r, input int i,
                       input bit rs, output int c);
    @(posedge clk);
    #1;
    rst     = rs;
    din_dv  = v;
    sync_in = s;
    din_dr  = DW'(r);
    din_di  = DW'(i);
    c       = cyc;
  endtask

  task automatic idle(input int n);
    int c;
    for (int k = 0; k < n; k++) drive(1'b0, 1'b0, 0, 0, 1'b0, c);
  endtask

  task automatic send(input int sr, input int si, input int ar, input int ai,
                      input int br, input int bi, input bit sy, output int t0);
    int c;
    drive(1'b1, sy, sr, si, 1'b0, t0);
    drive(1'b1, 1'b0, ar, ai, 1'b0, c);
    drive(1'b1, 1'b0, br, bi, 1'b0, c);
  endtask

  function automatic int clampv(input int x);
    return (x > VMAX) ? VMAX : ((x < VMIN) ? VMIN : x);
  endfunction

  function automatic int wrapv(input int x);
    int m;
    m = (x - VMIN) % 262144;
    if (m < 0) m += 262144;
    return m + VMIN;
  endfunction

  function automatic bit outr(input int x);
    return (x > VMAX) || (x < VMIN);
  endfunction

  function automatic int rnd();
    return int'($urandom_range(262143, 0)) + VMIN;
  endfunction

  task automatic push_vec(input vec_t v, input int t0, input bit sy);
    exp_t e;
    e.t0 = t0; e.sy = sy;
    e.sr = v.sr; e.si = v.si;
    e.y1r = v.y1r; e.y1i = v.y1i; e.y2r = v.y2r; e.y2i = v.y2i;
    e.o1 = v.o1; e.o2 = v.o2;
    e.w1r = v.w1r; e.w1i = v.w1i; e.w2r = v.w2r; e.w2i = v.w2i;
    e.wo1 = v.wo1; e.wo2 = v.wo2;
    expq.push_back(e);
  endtask

  task automatic push_model(input int sr, input int si, input int ar, input int ai,
                            input int br, input int bi, input int t0, input bit sy);
    exp_t e;
    e.t0 = t0; e.sy = sy; e.sr = sr; e.si = si;
    e.y1r = clampv(ar + br); e.y1i = clampv(ai + bi);
    e.y2r = clampv(ar - br); e.y2i = clampv(ai - bi);
    e.w1r = wrapv(ar + br);  e.w1i = wrapv(ai + bi);
    e.w2r = wrapv(ar - br);  e.w2i = wrapv(ai - bi);
    e.o1 = outr(ar + br) | outr(ai + bi);
    e.o2 = outr(ar - br) | outr(ai - bi);
    e.wo1 = e.o1; e.wo2 = e.o2;
    expq.push_back(e);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
    $fatal(1);
  end

  initial begin
    vec_t vecs[6];
    int   t0, c, c0, first_t0, last_t0, cnt;
    int   sr, si, ar, ai, br, bi;

    vecs[0] = '{100, -7, 50, 20, 30, -4, 80, 16, 20, 24, 1'b0, 1'b0,
                80, 16, 20, 24, 1'b0, 1'b0};
    vecs[1] = '{-131072, 131071, 131071, -131072, 10, 10,
                131071, -131062, 131061, -131072, 1'b1, 1'b1,
                -131063, -131062, 131061, 131062, 1'b1, 1'b1};
    vecs[2] = '{0, 0, -100, -100, -100, 100, -200, 0, 0, -200, 1'b0, 1'b0,
                -200, 0, 0, -200, 1'b0, 1'b0};
    vecs[3] = '{5, 6, -131072, 0, 1, -1, -131071, -1, -131072, 1, 1'b0, 1'b1,
                -131071, -1, 131071, 1, 1'b0, 1'b1};
    vecs[4] = '{-1, 1, 131071, 131071, -131072, -131072, -1, -1, 131071, 131071,
                1'b0, 1'b1, -1, -1, -1, -1, 1'b0, 1'b1};
    vecs[5] = '{7, -8, 65536, -65536, 65536, 65535, 131071, -1, 0, -131071,
                1'b1, 1'b0, -131072, -1, 0, -131071, 1'b1, 1'b0};

    rst = 1'b1; din_dv = 1'b0; sync_in = 1'b0; din_dr = '0; din_di = '0;
    for (int k = 0; k < 3; k++) drive(1'b0, 1'b0, 0, 0, 1'b1, c);
    @(negedge clk);
    chk("reset dout_dr", $signed(dout_dr), 0);
    chk("reset dout_di", $signed(dout_di), 0);
    chk("reset dout_dv", dout_dv, 0);
    chk("reset sync_out", sync_out, 0);
    chk("reset ovf", ovf, 0);
    chk("reset err", err, 0);
    idle(2);

    // Table: one idle cycle between triples; first triple carries sync.
    for (int k = 0; k < 6; k++) begin
      send(vecs[k].sr, vecs[k].si, vecs[k].ar, vecs[k].ai, vecs[k].br, vecs[k].bi,
           k == 0, t0);
      push_vec(vecs[k], t0, k == 0);
      idle(1);
      if (k == 0) begin
        idle(4);
        chk("vec0 dv before y0", lg_dv[t0+2], 0);
        chk("vec0 dv after y2", lg_dv[t0+6], 0);
        chk("vec0 err", lg_err[t0+3] | lg_err[t0+4] | lg_err[t0+5], 0);
      end
    end
    idle(3);

    // din_dv dropped after A: y0 survives, y1/y2 suppressed, next triple clean.
    send(11, 12, 0, 0, 0, 0, 1'b0, c);
    c0 = c;
    drive(1'b0, 1'b0, 0, 0, 1'b0, c);
    idle(0);
    begin
      int cs;
      drive(1'b1, 1'b0, 0, 0, 1'b0, cs);
    end
    idle(0);
    // (the above drives are re-sequenced below; see explicit sequence)
    idle(6);
    drive(1'b1, 1'b0, 21, -22, 1'b0, c0);
    drive(1'b1, 1'b0, 3, 4, 1'b0, c);
    drive(1'b0, 1'b0, 0, 0, 1'b0, c);
    send(300, -300, 1000, 2000, -500, 700, 1'b0, t0);
    push_model(300, -300, 1000, 2000, -500, 700, t0, 1'b0);
    idle(7);
    chk("drop y0 dv", lg_dv[c0+3], 1);
    chk("drop y0 re", lg_r[c0+3], 21);
    chk("drop y0 im", lg_i[c0+3], -22);
    chk("drop err pulse", lg_err[c0+3], 1);
    chk("drop err width", lg_err[c0+4], 0);
    chk("drop y1 dv", lg_dv[c0+4], 0);
    chk("drop y2 dv", lg_dv[c0+5], 0);

    // sync_in in phase 2: abort, then the sync sample opens a new triple.
    drive(1'b1, 1'b0, 41, 42, 1'b0, c0);
    drive(1'b1, 1'b0, 5, 5, 1'b0, c);
    send(-600, 600, 123, -456, 77, 88, 1'b1, t0);
    push_model(-600, 600, 123, -456, 77, 88, t0, 1'b1);
    idle(7);
    chk("sync-abort y0 re", lg_r[c0+3], 41);
    chk("sync-abort y0 dv", lg_dv[c0+3], 1);
    chk("sync-abort err", lg_err[c0+3], 1);
    chk("sync-abort A slot dv", lg_dv[c0+4], 0);
    chk("sync-abort old sync_out", lg_sy[c0+3], 0);

    // 100 back-to-back random triples.
    first_t0 = 0; last_t0 = 0;
    for (int k = 0; k < 100; k++) begin
      sr = rnd(); si = rnd(); ar = rnd(); ai = rnd(); br = rnd(); bi = rnd();
      send(sr, si, ar, ai, br, bi, 1'b0, t0);
      push_model(sr, si, ar, ai, br, bi, t0, 1'b0);
      if (k == 0) first_t0 = t0;
      last_t0 = t0;
    end
    idle(7);
    cnt = 0;
    for (int t = first_t0 + 3; t <= last_t0 + 5; t++) if (!lg_dv[t]) cnt++;
    chk("b2b dv gaps", cnt, 0);
    cnt = 0;
    for (int t = first_t0 + 1; t <= last_t0 + 5; t++) if (lg_err[t]) cnt++;
    chk("b2b err count", cnt, 0);

    // Reset during phase 1, then a clean triple.
    drive(1'b1, 1'b1, 999, 999, 1'b0, c0);
    drive(1'b1, 1'b0, 888, 888, 1'b1, c);
    drive(1'b0, 1'b0, 0, 0, 1'b1, c);
    @(negedge clk);
    chk("midrst dout_dr", $signed(dout_dr), 0);
    chk("midrst dout_dv", dout_dv, 0);
    chk("midrst sync_out", sync_out, 0);
    idle(2);
    send(-1234, 4321, 10, 20, 30, 40, 1'b0, t0);
    push_model(-1234, 4321, 10, 20, 30, 40, t0, 1'b0);
    idle(8);
    cnt = 0;
    for (int t = c0 + 2; t <= t0 + 2; t++) if (lg_dv[t] || lg_sy[t]) cnt++;
    chk("midrst stale outputs", cnt, 0);

    // Scoreboard: every recorded triple against its expected outputs.
    foreach (expq[q]) begin
      exp_t e;
      int   t;
      e = expq[q];
      t = e.t0;
      chk($sformatf("tr%0d y0 dv", q), lg_dv[t+3], 1);
      chk($sformatf("tr%0d y1 dv", q), lg_dv[t+4], 1);
      chk($sformatf("tr%0d y2 dv", q), lg_dv[t+5], 1);
      chk($sformatf("tr%0d y0 re", q), lg_r[t+3], e.sr);
      chk($sformatf("tr%0d y0 im", q), lg_i[t+3], e.si);
      chk($sformatf("tr%0d y1 re", q), lg_r[t+4], e.y1r);
      chk($sformatf("tr%0d y1 im", q), lg_i[t+4], e.y1i);
      chk($sformatf("tr%0d y2 re", q), lg_r[t+5], e.y2r);
      chk($sformatf("tr%0d y2 im", q), lg_i[t+5], e.y2i);
      chk($sformatf("tr%0d sync_out", q), lg_sy[t+3], e.sy);
      chk($sformatf("tr%0d ovf y0", q), lg_ovf[t+3], 0);
      chk($sformatf("tr%0d ovf y1", q), lg_ovf[t+4], e.o1);
      chk($sformatf("tr%0d ovf y2", q), lg_ovf[t+5], e.o2);
      chk($sformatf("tr%0d wrap y1 re", q), lg_wr[t+4], e.w1r);
      chk($sformatf("tr%0d wrap y1 im", q), lg_wi[t+4], e.w1i);
      chk($sformatf("tr%0d wrap y2 re", q), lg_wr[t+5], e.w2r);
      chk($sformatf("tr%0d wrap y2 im", q), lg_wi[t+5], e.w2i);
      chk($sformatf("tr%0d wrap ovf y1", q), lg_wovf[t+4], e.wo1);
      chk($sformatf("tr%0d wrap ovf y2", q), lg_wovf[t+5], e.wo2);
      $display("triple %0d t0=%0d y0=(%0d,%0d) y1=(%0d,%0d) y2=(%0d,%0d)", q, t,
               lg_r[t+3], lg_i[t+3], lg_r[t+4], lg_i[t+4], lg_r[t+5], lg_i[t+5]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
